// File: rtl/dac_tx_pkg.sv
// Shared constants for the DAC TX FIFO controller: word-index register map,
// CTRL/STATUS bit positions, unmapped read value and reset low-water mark.
package dac_tx_pkg;

  localparam int unsigned REG_CTRL_IDX   = 0;
  localparam int unsigned REG_STATUS_IDX = 1;
  localparam int unsigned REG_THRESH_IDX = 2;
  localparam int unsigned REG_UNDCNT_IDX = 3;
  localparam int unsigned REG_DATA_IDX   = 4;

  localparam int unsigned CTRL_TX_EN  = 0;
  localparam int unsigned CTRL_FLUSH  = 1;
  localparam int unsigned CTRL_IRQ_EN = 2;

  localparam int unsigned ST_EMPTY   = 0;
  localparam int unsigned ST_FULL    = 1;
  localparam int unsigned ST_UND     = 2;
  localparam int unsigned ST_OVF     = 3;
  localparam int unsigned ST_LVL_LSB = 16;

  localparam logic [31:0] DEF_REG_VAL_C = 32'hFABD_EFAC;

  function automatic int unsigned rst_thresh(input int unsigned depth);
    return depth / 2;
  endfunction

endpackage

// File: rtl/tx_sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO: the head word is visible as soon
// as the level is non-zero; flush empties it in one cycle.
module tx_sync_fifo_fwft #(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 512,
  parameter int unsigned LVLW  = $clog2(DEPTH) + 1
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            push_i,
  input  logic [DW-1:0]   data_i,
  input  logic            pop_i,
  input  logic            flush_i,
  output logic [DW-1:0]   head_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [LVLW-1:0] level_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [DW-1:0]   mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVLW-1:0] level_q, level_d;
  logic            do_push, do_pop;

  assign full_o  = (level_q == LVLW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign head_o  = mem_q[rd_ptr_q];

  // full is judged before any same-cycle pop, so push-while-full is dropped
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/dac_tx_fifo_ctrl.sv
// Wishbone-fed TX sample FIFO controller with valid/ready drain, DMA low-water
// request and underrun/overflow IRQ. Define DAC_TX_UNDERRUN_CNT_EN for UNDCNT.
module dac_tx_fifo_ctrl
  import dac_tx_pkg::*;
#(
  parameter int unsigned ADDRWIDTH  = 10,
  parameter int unsigned DATAWIDTH  = 32,
  parameter int unsigned FIFO_DEPTH = 512,
  parameter logic [DATAWIDTH-1:0] DEF_REG_VAL = DATAWIDTH'(DEF_REG_VAL_C)
) (
  input  logic                 WBs_CLK_i,
  input  logic                 WBs_RST_N_i,
  input  logic [ADDRWIDTH-1:0] WBs_ADR_i,
  input  logic                 WBs_CYC_i,
  input  logic                 WBs_STB_i,
  input  logic                 WBs_WE_i,
  input  logic [3:0]           WBs_BYTE_STB_i,
  input  logic [DATAWIDTH-1:0] WBs_DAT_i,
  output logic [DATAWIDTH-1:0] WBs_DAT_o,
  output logic                 WBs_ACK_o,
  output logic [DATAWIDTH-1:0] Tx_Data_o,
  output logic                 Tx_Valid_o,
  input  logic                 Tx_Ready_i,
  output logic                 DMA_REQ_o,
  output logic                 Tx_IRQ_o
);

  localparam int unsigned LVLW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned IW   = ADDRWIDTH - 2;
  localparam logic [IW-1:0] A_CTRL   = IW'(REG_CTRL_IDX);
  localparam logic [IW-1:0] A_STATUS = IW'(REG_STATUS_IDX);
  localparam logic [IW-1:0] A_THRESH = IW'(REG_THRESH_IDX);
  localparam logic [IW-1:0] A_DATA   = IW'(REG_DATA_IDX);
  localparam logic [LVLW-1:0] THRESH_RST = LVLW'(rst_thresh(FIFO_DEPTH));

  logic [IW-1:0]        idx;
  logic [1:0]           unused_adr;
  logic                 wr_acc, wr_ctrl, wr_status, wr_thresh, wr_data;
  logic                 ack_q, ack_d;
  logic                 tx_en_q, tx_en_d, irq_en_q, irq_en_d;
  logic [LVLW-1:0]      thresh_q, thresh_d;
  logic                 und_q, und_d, ovf_q, ovf_d;
  logic                 armed_q, armed_d;
  logic                 dma_q, dma_d;
  logic                 flush, pop, und_evt, ovf_evt;
  logic [DATAWIDTH-1:0] head;
  logic                 full, empty;
  logic [LVLW-1:0]      level;
  logic [DATAWIDTH-1:0] rd_data;

  assign idx        = WBs_ADR_i[ADDRWIDTH-3:0];
  assign unused_adr = WBs_ADR_i[ADDRWIDTH-1:ADDRWIDTH-2];

  assign wr_acc    = WBs_CYC_i & WBs_STB_i & WBs_WE_i & ~ack_q;
  assign wr_ctrl   = wr_acc & (idx == A_CTRL);
  assign wr_status = wr_acc & (idx == A_STATUS);
  assign wr_thresh = wr_acc & (idx == A_THRESH);
  assign wr_data   = wr_acc & (idx == A_DATA) & (WBs_BYTE_STB_i == 4'hF);

  assign flush   = wr_ctrl & WBs_DAT_i[CTRL_FLUSH];
  assign Tx_Valid_o = tx_en_q & ~empty;
  assign pop     = Tx_Valid_o & Tx_Ready_i;
  assign ovf_evt = wr_data & full;
  // only counts as underrun once the stream has actually started
  assign und_evt = tx_en_q & Tx_Ready_i & ~Tx_Valid_o & armed_q;

  tx_sync_fifo_fwft #(
    .DW   (DATAWIDTH),
    .DEPTH(FIFO_DEPTH),
    .LVLW (LVLW)
  ) u_fifo (
    .clk_i  (WBs_CLK_i),
    .rst_n_i(WBs_RST_N_i),
    .push_i (wr_data),
    .data_i (WBs_DAT_i),
    .pop_i  (pop),
    .flush_i(flush),
    .head_o (head),
    .full_o (full),
    .empty_o(empty),
    .level_o(level)
  );

  assign Tx_Data_o = Tx_Valid_o ? head : '0;
  assign WBs_ACK_o = ack_q;
  assign DMA_REQ_o = dma_q;
  assign Tx_IRQ_o  = (und_q | ovf_q) & irq_en_q;

  always_comb begin
    ack_d    = WBs_CYC_i & WBs_STB_i & ~ack_q;
    tx_en_d  = tx_en_q;
    irq_en_d = irq_en_q;
    thresh_d = thresh_q;
    und_d    = und_q;
    ovf_d    = ovf_q;
    if (wr_ctrl) begin
      tx_en_d  = WBs_DAT_i[CTRL_TX_EN];
      irq_en_d = WBs_DAT_i[CTRL_IRQ_EN];
    end
    if (wr_thresh) thresh_d = WBs_DAT_i[LVLW-1:0];
    if (wr_status && WBs_DAT_i[ST_UND]) und_d = 1'b0;
    if (wr_status && WBs_DAT_i[ST_OVF]) ovf_d = 1'b0;
    if (und_evt) und_d = 1'b1;
    if (ovf_evt) ovf_d = 1'b1;
    armed_d = tx_en_q & (armed_q | pop);
    dma_d   = tx_en_q & (level <= thresh_q);
  end

  always_ff @(posedge WBs_CLK_i or negedge WBs_RST_N_i) begin
    if (!WBs_RST_N_i) begin
      ack_q    <= 1'b0;
      tx_en_q  <= 1'b0;
      irq_en_q <= 1'b0;
      thresh_q <= THRESH_RST;
      und_q    <= 1'b0;
      ovf_q    <= 1'b0;
      armed_q  <= 1'b0;
      dma_q    <= 1'b0;
    end else begin
      ack_q    <= ack_d;
      tx_en_q  <= tx_en_d;
      irq_en_q <= irq_en_d;
      thresh_q <= thresh_d;
      und_q    <= und_d;
      ovf_q    <= ovf_d;
      armed_q  <= armed_d;
      dma_q    <= dma_d;
    end
  end

`ifdef DAC_TX_UNDERRUN_CNT_EN
  localparam logic [IW-1:0] A_UNDCNT = IW'(REG_UNDCNT_IDX);
  logic        wr_undcnt;
  logic [15:0] undcnt_q, undcnt_d;

  assign wr_undcnt = wr_acc & (idx == A_UNDCNT);

  always_comb begin
    undcnt_d = undcnt_q;
    if (wr_undcnt)                         undcnt_d = {15'd0, und_evt};
    else if (und_evt && undcnt_q != 16'hFFFF) undcnt_d = undcnt_q + 16'd1;
  end

  always_ff @(posedge WBs_CLK_i or negedge WBs_RST_N_i) begin
    if (!WBs_RST_N_i) undcnt_q <= '0;
    else              undcnt_q <= undcnt_d;
  end
`endif

  always_comb begin
    rd_data = DEF_REG_VAL;
    case (idx)
      A_CTRL: begin
        rd_data              = '0;
        rd_data[CTRL_TX_EN]  = tx_en_q;
        rd_data[CTRL_IRQ_EN] = irq_en_q;
      end
      A_STATUS: begin
        rd_data                      = '0;
        rd_data[ST_EMPTY]            = empty;
        rd_data[ST_FULL]             = full;
        rd_data[ST_UND]              = und_q;
        rd_data[ST_OVF]              = ovf_q;
        rd_data[ST_LVL_LSB +: LVLW]  = level;
      end
      A_THRESH: begin
        rd_data           = '0;
        rd_data[LVLW-1:0] = thresh_q;
      end
`ifdef DAC_TX_UNDERRUN_CNT_EN
      A_UNDCNT: rd_data = DATAWIDTH'(undcnt_q);
`endif
      default: rd_data = DEF_REG_VAL;
    endcase
  end

  assign WBs_DAT_o = rd_data;

endmodule
